// File: rtl/up_down_counter.sv
// 8-bit programmable up/down counter (step 1..16, wrap or saturate, parallel load).
// Optional status outputs on the bidir bus are enabled by defining COUNTER_STATUS_EN.
module up_down_counter #(
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic       cnt_en;
    logic       up;
    logic       load;
    logic       sat;
    logic [3:0] step_m1;

    assign cnt_en  = ui_in[0];
    assign up      = ui_in[1];
    assign load    = ui_in[2];
    assign sat     = ui_in[3];
    assign step_m1 = ui_in[7:4];

    logic [7:0] count;
    logic [7:0] count_next;
    logic [7:0] load_val;
    logic       bound_next;
    logic [8:0] step;
    logic [8:0] sum;
    logic [8:0] diff;

    // Bit 8 of sum is the carry out; bit 8 of diff is the borrow (step > count).
    assign step = {5'b0_0000, step_m1} + 9'd1;
    assign sum  = {1'b0, count} + step;
    assign diff = {1'b0, count} - step;

    // NOTE: every output of this block is given a default first, so no latch is inferred.
    always_comb begin
        count_next = count;
        bound_next = 1'b0;
        if (load) begin
            count_next = load_val;
        end else if (cnt_en) begin
            if (up) begin
                count_next = (sum[8] && sat) ? 8'hFF : sum[7:0];
                bound_next = sum[8];
            end else begin
                count_next = (diff[8] && sat) ? 8'h00 : diff[7:0];
                bound_next = diff[8];
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RESET_VALUE;
        end else if (ena) begin
            count <= count_next;
        end
    end

    assign uo_out = count;

`ifdef COUNTER_STATUS_EN
    logic       bound_q;
    logic [1:0] unused_uio;

    always_ff @(posedge clk) begin
        if (rst) begin
            bound_q <= 1'b0;
        end else if (ena) begin
            bound_q <= bound_next;
        end
    end

    // Upper two bus bits are status outputs, so the load value only uses the low six.
    assign load_val   = {2'b00, uio_in[5:0]};
    assign unused_uio = uio_in[7:6];
    assign uio_out    = {bound_q, (count == 8'h00), 6'b00_0000};
    assign uio_oe     = 8'hC0;
`else
    logic unused_bound;

    assign load_val     = uio_in;
    assign unused_bound = bound_next;
    assign uio_out      = 8'h00;
    assign uio_oe       = 8'h00;
`endif

endmodule

// File: tb/tb_up_down_counter.sv
// Scoreboard bench for up_down_counter: driver queues hand-computed expectations,
// a monitor pops and compares one entry after every rising edge.
module tb_up_down_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    up_down_counter #(.RESET_VALUE(8'h00)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

`ifdef COUNTER_STATUS_EN
    localparam logic [7:0] LOAD_55 = 8'h15;
    localparam logic [7:0] LOAD_FF = 8'h3F;
    localparam logic [7:0] EXP_OE  = 8'hC0;
`else
    localparam logic [7:0] LOAD_55 = 8'h55;
    localparam logic [7:0] LOAD_FF = 8'hFF;
    localparam logic [7:0] EXP_OE  = 8'h00;
`endif

    logic [7:0] exp_cnt_q[$];
    logic       exp_bnd_q[$];
    string      exp_name_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
        end
    endtask

    // One cycle of stimulus plus the state expected after the following rising edge.
    task automatic cyc(input logic r, input logic e, input logic [7:0] ui, input logic [7:0] ld,
                       input logic [7:0] exp_cnt, input logic exp_bnd, input string name);
        @(negedge clk);
        rst    = r;
        ena    = e;
        ui_in  = ui;
        uio_in = ld;
        exp_cnt_q.push_back(exp_cnt);
        exp_bnd_q.push_back(exp_bnd);
        exp_name_q.push_back(name);
    endtask

    initial begin : monitor
        logic [7:0] c;
        logic       b;
        logic [7:0] st;
        string      nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_cnt_q.size() > 0) begin
                c  = exp_cnt_q.pop_front();
                b  = exp_bnd_q.pop_front();
                nm = exp_name_q.pop_front();
`ifdef COUNTER_STATUS_EN
                st = {b, (c == 8'h00), 6'b00_0000};
`else
                st = 8'h00;
`endif
                check({nm, " count"}, uo_out, c);
                check({nm, " status"}, uio_out, st);
                check({nm, " oe"}, uio_oe, EXP_OE);
            end
        end
    end

    // ui_in encoding: {step_m1[3:0], sat, load, up, cnt_en}
    initial begin : driver
        rst    = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        cyc(1, 1, 8'h07, 8'hAA, 8'h00, 0, "reset");
        for (int i = 1; i <= 10; i++)
            cyc(0, 1, 8'h03, 8'h00, 8'(i), 0, $sformatf("up1_%0d", i));
        cyc(0, 1, 8'h00, 8'h00, 8'h0A, 0, "hold");

        cyc(0, 1, 8'h04, 8'h01, 8'h01, 0, "load01_a");
        cyc(0, 1, 8'h21, 8'h00, 8'hFE, 1, "dn3_wrap");
        cyc(0, 1, 8'h33, 8'h00, 8'h02, 1, "up4_wrap");
        cyc(0, 1, 8'h00, 8'h00, 8'h02, 0, "pulse_end");

        cyc(0, 1, 8'h04, 8'h01, 8'h01, 0, "load01_b");
        cyc(0, 1, 8'h21, 8'h00, 8'hFE, 1, "dn3_wrap_b");
        cyc(0, 1, 8'h3B, 8'h00, 8'hFF, 1, "up4_sat");
        cyc(0, 1, 8'h3B, 8'h00, 8'hFF, 1, "up4_sat_hold");
        cyc(0, 1, 8'h00, 8'h00, 8'hFF, 0, "sat_idle");

        cyc(0, 1, 8'h04, 8'h03, 8'h03, 0, "load03_a");
        cyc(0, 1, 8'h41, 8'h00, 8'hFE, 1, "dn5_wrap");
        cyc(0, 1, 8'h04, 8'h03, 8'h03, 0, "load03_b");
        cyc(0, 1, 8'h49, 8'h00, 8'h00, 1, "dn5_sat");
        cyc(0, 1, 8'h00, 8'h00, 8'h00, 0, "zero_idle");
        cyc(0, 1, 8'h04, 8'h03, 8'h03, 0, "load03_c");
        cyc(0, 1, 8'h29, 8'h00, 8'h00, 0, "dn3_exact");
        cyc(0, 1, 8'hF3, 8'h00, 8'h10, 0, "up16");

        cyc(0, 1, 8'h07, 8'h55, LOAD_55, 0, "load_wins");
        cyc(0, 0, 8'h03, 8'h00, LOAD_55, 0, "ena0_cnt");
        cyc(0, 0, 8'h04, 8'h11, LOAD_55, 0, "ena0_load");

        cyc(0, 1, 8'h04, 8'h3F, 8'h3F, 0, "load3F");
        cyc(0, 1, 8'h03, 8'h00, 8'h40, 0, "up_to_40");
        cyc(1, 1, 8'h03, 8'h00, 8'h00, 0, "rst_mid");
        cyc(0, 1, 8'h04, 8'h05, 8'h05, 0, "load05");
        cyc(1, 0, 8'h03, 8'h00, 8'h00, 0, "rst_ena0");
        cyc(0, 1, 8'h04, 8'hFF, LOAD_FF, 0, "loadFF_mask");
        cyc(0, 1, 8'h00, 8'h00, LOAD_FF, 0, "final_hold");

        repeat (3) @(posedge clk);
        #2;
        if (exp_cnt_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", exp_cnt_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
